// File: rtl/carlosgs99_multi_4bits.sv
// -----------------------------------------------------------------------------
// carlosgs99_multi_4bits
//
// Unsigned WIDTH x WIDTH sequential shift-and-add multiplier with a registered
// 2*WIDTH-bit product. A start is accepted only in IDLE. The product register
// holds the previous result until the final add of the next operation.
//
// Timing (WIDTH=4):
//   - Edge 1 captures the operands and moves the FSM to CALC.
//   - Edges 2..5 perform the four add/shift steps.
//   - The new product is visible after edge 5.
//   - If ena is held high, edge 6 captures the next operands.
//
// Ports:
//   clk        - system clock; all state updates on the rising edge
//   rst_n      - synchronous reset, ACTIVE-HIGH despite the name
//   ena        - start enable, sampled only in IDLE
//   io_A       - multiplicand, unsigned, WIDTH bits
//   io_B       - multiplier, unsigned, WIDTH bits
//   io_Product - registered product io_A*io_B, 2*WIDTH bits
// -----------------------------------------------------------------------------
module carlosgs99_multi_4bits #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [WIDTH-1:0]     io_A,
  input  logic [WIDTH-1:0]     io_B,
  output logic [2*WIDTH-1:0]   io_Product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  mcand;     // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier;  // multiplier, shifted right each step
  logic [PW-1:0]  acc;
  logic [PW-1:0]  acc_sum;   // accumulator value after this step's add
  logic [CW-1:0]  cnt;
  logic           last_step;

  assign last_step = (cnt == CW'(WIDTH - 1));

  // The product width is 2*WIDTH, so the largest result (2^W-1)^2 always fits
  // and this add can never wrap.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  // State register. Reset is checked first so it overrides any start or
  // operation in progress.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: the default is assigned before the case so every path drives
  // state_nxt; a missing assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ena)       state_nxt = CALC;
      CALC:    if (last_step) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath and product register.
  // NOTE: every datapath register is reset along with the FSM. This keeps the
  // block free of X after the first reset edge, even though the operand
  // registers are reloaded before use.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      io_Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ena) begin
            mcand  <= {{WIDTH{1'b0}}, io_A};
            mplier <= io_B;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // The result is loaded from acc_sum so that it includes this
          // edge's add. Only a finished result ever reaches the output.
          if (last_step) begin
            io_Product <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carlosgs99_multi_4bits.sv
// -----------------------------------------------------------------------------
// tb_carlosgs99_multi_4bits
//
// Directed, table-driven bench for the 4x4 sequential multiplier.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at the same point, well clear of the active edge.
// -----------------------------------------------------------------------------
module tb_carlosgs99_multi_4bits;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] io_A;
  logic [3:0] io_B;
  logic [7:0] io_Product;

  int total = 0;
  int bad   = 0;

  // Product the bench expects to see on the output right now.
  logic [7:0] last_prod;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [7];

  carlosgs99_multi_4bits #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .io_A       (io_A),
    .io_B       (io_B),
    .io_Product (io_Product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a multiply with (a,b). After the capture edge, drive (ma,mb) so
  // that any leakage of mid-operation operand changes is visible. The
  // previous product must hold through edges 1..4, and the new product
  // must appear after edge 5.
  task automatic run_op(input string name,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ma, input logic [3:0] mb,
                        input logic [7:0] exp);
    io_A = a;
    io_B = b;
    ena  = 1'b1;
    tick();
    ena  = 1'b0;
    io_A = ma;
    io_B = mb;
    check({name, "_hold_e1"}, io_Product, last_prod);
    for (int e = 2; e <= 4; e++) begin
      tick();
      check($sformatf("%s_hold_e%0d", name, e), io_Product, last_prod);
    end
    tick();
    check({name, "_result"}, io_Product, exp);
    last_prod = exp;
  endtask

  initial begin
    // Expected products, computed by hand.
    vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[1] = '{a: 4'd15, b: 4'd1,  p: 8'h0F};
    vecs[2] = '{a: 4'd1,  b: 4'd15, p: 8'h0F};
    vecs[3] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  p: 8'h40};
    vecs[5] = '{a: 4'd13, b: 4'd11, p: 8'h8F};
    vecs[6] = '{a: 4'd6,  b: 4'd10, p: 8'h3C};

    // Reset held for two edges, with a start request and operands present.
    rst_n = 1'b1;
    ena   = 1'b1;
    io_A  = 4'hF;
    io_B  = 4'hF;
    tick();
    check("reset_e1", io_Product, 8'h00);
    tick();
    check("reset_e2", io_Product, 8'h00);
    rst_n = 1'b0;
    ena   = 1'b0;
    last_prod = 8'h00;
    tick();
    check("post_reset_idle", io_Product, 8'h00);

    // Basic operation, followed by a hold through idle cycles.
    run_op("basic_3x5", 4'd3, 4'd5, 4'd3, 4'd5, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("basic_idle_hold_%0d", i), io_Product, 8'h0F);
    end

    // Table of extremes and assorted operands.
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
             ~vecs[i].a, ~vecs[i].b, vecs[i].p);
    end

    // Operands change during CALC: 7*6 = 42, not 2*2.
    run_op("mid_change_7x6", 4'd7, 4'd6, 4'd2, 4'd2, 8'h2A);

    // Back-to-back with ena held high.
    ena  = 1'b1;
    io_A = 4'd2;
    io_B = 4'd3;
    tick();                      // edge 1: capture 2,3
    io_A = 4'd4;
    io_B = 4'd4;
    for (int e = 2; e <= 4; e++) begin
      tick();
      check($sformatf("b2b_first_hold_e%0d", e), io_Product, last_prod);
    end
    tick();                      // edge 5
    check("b2b_first_result", io_Product, 8'h06);
    tick();                      // edge 6: capture 4,4
    ena = 1'b0;
    check("b2b_hold_e6", io_Product, 8'h06);
    for (int e = 7; e <= 9; e++) begin
      tick();
      check($sformatf("b2b_second_hold_e%0d", e), io_Product, 8'h06);
    end
    tick();                      // edge 10
    check("b2b_second_result", io_Product, 8'h10);
    last_prod = 8'h10;

    // Reset asserted on the 3rd CALC edge aborts the operation.
    ena  = 1'b1;
    io_A = 4'd9;
    io_B = 4'd9;
    tick();                      // edge 1: capture
    ena = 1'b0;
    tick();                      // CALC edge 1
    tick();                      // CALC edge 2
    check("abort_hold_before_reset", io_Product, 8'h10);
    rst_n = 1'b1;
    tick();                      // CALC edge 3, with reset applied
    check("abort_reset_clears", io_Product, 8'h00);
    rst_n = 1'b0;
    last_prod = 8'h00;
    // With ena low, no late result may appear from the aborted operation.
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort_idle_%0d", i), io_Product, 8'h00);
    end
    run_op("restart_9x9", 4'd9, 4'd9, 4'd9, 4'd9, 8'h51);

    // Reset and ena asserted on the same edge: reset wins and no capture
    // occurs, so no result may ever appear.
    rst_n = 1'b1;
    ena   = 1'b1;
    io_A  = 4'd5;
    io_B  = 4'd5;
    tick();
    rst_n = 1'b0;
    ena   = 1'b0;
    check("reset_vs_ena", io_Product, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("reset_vs_ena_idle_%0d", i), io_Product, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
